// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_e;

  function automatic int off_w(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int idx_w(input int nlines);
    return $clog2(nlines);
  endfunction

  // Tag is whatever remains above word offset, line offset and index.
  function automatic int tag_w(input int nlines, input int wpl);
    return 30 - $clog2(wpl) - $clog2(nlines);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// NLINES x WPL word store: one synchronous write port, one combinational read port.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int NLINES = 16,
  parameter int WPL    = 4,
  localparam int IDX_W = idx_w(NLINES),
  localparam int OFF_W = off_w(WPL)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [OFF_W-1:0] woff,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  input  logic [OFF_W-1:0] roff,
  output logic [31:0]      rdata
);

  // Contents are intentionally not reset; the valid bits guard them.
  logic [31:0] mem_q [NLINES][WPL];

  always_ff @(posedge clk) begin
    if (we) mem_q[widx][woff] <= wdata;
  end

  assign rdata = mem_q[ridx][roff];

endmodule

// File: rtl/icache.sv
// Direct-mapped blocking instruction cache with a beat-serial refill FSM.
// Optional statistics counters are built only when ICACHE_STATS_EN is defined.
module icache
  import icache_pkg::*;
#(
  parameter int NLINES = 16,
  parameter int WPL    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] pcF,
  input  logic        inval,
  output logic [31:0] instrF,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W = off_w(WPL);
  localparam int IDX_W = idx_w(NLINES);
  localparam int TAG_W = tag_w(NLINES, WPL);

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign off = pcF[OFF_W+1:2];
  assign idx = pcF[OFF_W+IDX_W+1 -: IDX_W];
  assign tag = pcF[31 -: TAG_W];

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^pcF[1:0];

  state_e                       state_q, state_d;
  logic [NLINES-1:0]            valid_q, valid_d;
  logic [NLINES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [31:0]                  base_q, base_d;
  logic [OFF_W-1:0]             beat_q, beat_d;
  logic                         pend_q, pend_d;

  logic             hit, we, last;
  logic [IDX_W-1:0] refill_idx;
  logic [TAG_W-1:0] refill_tag;

  assign hit        = valid_q[idx] & (tag_q[idx] == tag);
  assign refill_idx = base_q[OFF_W+IDX_W+1 -: IDX_W];
  assign refill_tag = base_q[31 -: TAG_W];
  assign we         = (state_q == S_REFILL) & mem_ready;
  assign last       = (beat_q == OFF_W'(WPL-1));

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    base_d   = base_q;
    beat_d   = beat_q;
    pend_d   = pend_q;
    stall    = 1'b0;
    mem_req  = 1'b0;
    mem_addr = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (en && !hit) begin
          stall   = 1'b1;
          state_d = S_REFILL;
          base_d  = {pcF[31:OFF_W+2], {(OFF_W+2){1'b0}}};
          beat_d  = '0;
          pend_d  = 1'b0;
        end
        // Lookup above still sees the pre-clear valid bits.
        if (inval) valid_d = '0;
      end
      S_REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_q + 32'({beat_q, 2'b00});
        if (inval) pend_d = 1'b1;
        if (mem_ready) begin
          beat_d = beat_q + 1'b1;
          if (last) begin
            state_d = S_IDLE;
            beat_d  = '0;
            // An invalidate seen during the refill also kills the new line.
            if (pend_d) valid_d = '0;
            else        valid_d[refill_idx] = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tag_d = tag_q;
    if (we && last) tag_d[refill_idx] = refill_tag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      base_q  <= '0;
      beat_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  icache_data_array #(
    .NLINES(NLINES),
    .WPL   (WPL)
  ) u_data (
    .clk  (clk),
    .we   (we),
    .widx (refill_idx),
    .woff (beat_q),
    .wdata(mem_rdata),
    .ridx (idx),
    .roff (off),
    .rdata(instrF)
  );

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (state_q == S_IDLE && en) begin
      if (hit && hit_q != 32'hFFFF_FFFF)    hit_d  = hit_q + 32'd1;
      if (!hit && miss_q != 32'hFFFF_FFFF)  miss_d = miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a line-level behavioural cache model.
module tb_icache;

  localparam int NL  = 16;
  localparam int WPL = 4;
  localparam logic [31:0] LINE_B = 32'(4 * WPL);

  logic        clk = 1'b0;
  logic        reset, en, inval, mem_ready;
  logic [31:0] pcF, mem_rdata;
  logic [31:0] instrF, mem_addr, hit_count, miss_count;
  logic        stall, mem_req;

  int checks = 0;
  int errors = 0;

  // Behavioural model: which lines are resident and what they hold.
  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];
  logic [31:0] m_data  [NL][WPL];
  int          n_hit, n_miss;
  bit          seq_mode;

  icache #(.NLINES(NL), .WPL(WPL)) dut (
    .clk(clk), .reset(reset), .en(en), .pcF(pcF), .inval(inval),
    .instrF(instrF), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (seq_mode) return 32'h1000 + (a % LINE_B);
    return (a * 32'h9E37_79B1) ^ 32'h00C3_5A00;
  endfunction

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    logic [31:0] eh, em;
`ifdef ICACHE_STATS_EN
    eh = n_hit;
    em = n_miss;
`else
    eh = 0;
    em = 0;
`endif
    checks++;
    if (hit_count !== eh || miss_count !== em) begin
      errors++;
      $display("FAIL stats_%s hit=%0d miss=%0d expected hit=%0d miss=%0d",
               tag, hit_count, miss_count, eh, em);
    end
  endtask

  // One fetch of addr, run to completion; lat = cycles mem_ready stays low per beat,
  // ib = beat on which inval pulses during the refill (-1 for none).
  task automatic fetch(input logic [31:0] addr, input int lat, input int ib);
    int idx, off, cur_ib;
    logic [31:0] tg, base, wd;
    bit hit, pend, done;
    idx    = int'((addr / LINE_B) % NL);
    off    = int'((addr / 4) % WPL);
    tg     = addr / (LINE_B * NL);
    base   = addr - (addr % LINE_B);
    cur_ib = ib;
    done   = 1'b0;
    for (int att = 0; att < 3 && !done; att++) begin
      en = 1'b1; pcF = addr; inval = 1'b0; mem_ready = 1'b0;
      hit = m_valid[idx] && (m_tag[idx] == tg);
      @(negedge clk);
      checks++;
      if (stall !== !hit) begin
        errors++;
        $display("FAIL lookup_stall addr=%h got %b expected %b", addr, stall, !hit);
      end
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
        errors++;
        $display("FAIL idle_mem addr=%h got req=%b maddr=%h expected 0/0", addr, mem_req, mem_addr);
      end
      if (hit) begin
        checks++;
        if (instrF !== m_data[idx][off]) begin
          errors++;
          $display("FAIL hit_data addr=%h got %h expected %h", addr, instrF, m_data[idx][off]);
        end
        n_hit++;
        done = 1'b1;
        tick();
      end else begin
        n_miss++;
        pend = 1'b0;
        tick();
        for (int b = 0; b < WPL; b++) begin
          for (int w = 0; w <= lat; w++) begin
            wd        = mem_word(base + 32'(4 * b));
            pcF       = $urandom;
            mem_ready = (w == lat);
            mem_rdata = wd;
            inval     = (b == cur_ib && w == 0);
            if (inval) pend = 1'b1;
            @(negedge clk);
            checks++;
            if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== base + 32'(4 * b)) begin
              errors++;
              $display("FAIL refill beat=%0d got stall=%b req=%b maddr=%h expected 1/1/%h",
                       b, stall, mem_req, mem_addr, base + 32'(4 * b));
            end
            tick();
            if (w == lat) m_data[idx][b] = wd;
          end
        end
        inval = 1'b0; mem_ready = 1'b0;
        if (pend) model_clear();
        else begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = tg;
        end
        cur_ib = -1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL fetch_no_hit addr=%h got miss expected hit after refill", addr);
    end
  endtask

  task automatic idle_cycle(input bit do_inval);
    en = 1'b0; inval = do_inval; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle got stall=%b req=%b expected 0/0", stall, mem_req);
    end
    tick();
    inval = 1'b0;
    if (do_inval) model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; inval = 1'b0; mem_ready = 1'b0; pcF = 0; mem_rdata = 0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b req=%b maddr=%h expected 0/0/0", stall, mem_req, mem_addr);
    end
    model_clear(); n_hit = 0; n_miss = 0;
    check_stats("reset");
    tick();
    reset = 1'b0;
    idle_cycle(1'b0);
  endtask

  task automatic test_basic_refill();
    seq_mode = 1'b1;
    fetch(32'h0000_0040, 0, -1);
    checks++;
    if (instrF !== 32'h0000_1000) begin
      errors++;
      $display("FAIL basic_word0 got %h expected %h", instrF, 32'h0000_1000);
    end
    fetch(32'h0000_0048, 0, -1);
    check_stats("basic");
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0140, 0, -1);
    fetch(32'h0000_0040, 0, -1);
    fetch(32'h0000_004C, 0, -1);
    check_stats("conflict");
  endtask

  task automatic test_slow_mem();
    seq_mode = 1'b0;
    fetch(32'h0000_0384, 3, -1);
    fetch(32'h0000_038C, 0, -1);
  endtask

  task automatic test_inval_refill();
    model_clear();
    idle_cycle(1'b1);
    fetch(32'h0000_0040, 1, 1);
  endtask

  task automatic test_inval_idle();
    fetch(32'h0000_0040, 0, -1);
    en = 1'b1; pcF = 32'h0000_0044; inval = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || instrF !== m_data[4][1]) begin
      errors++;
      $display("FAIL inval_idle_lookup got stall=%b instr=%h expected 0/%h", stall, instrF, m_data[4][1]);
    end
    n_hit++;
    tick();
    inval = 1'b0;
    model_clear();
    fetch(32'h0000_0044, 0, -1);
    check_stats("inval");
  endtask

  task automatic test_reset_mid_refill();
    en = 1'b1; pcF = 32'h0000_0500; mem_ready = 1'b0;
    @(negedge clk);
    tick();
    for (int b = 0; b < 3; b++) begin
      mem_ready = 1'b1;
      mem_rdata = mem_word(32'h0000_0500 + 32'(4 * b));
      reset     = (b == 2);
      tick();
    end
    reset = 1'b0; en = 1'b0; mem_ready = 1'b0;
    model_clear(); n_hit = 0; n_miss = 0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got req=%b maddr=%h stall=%b expected 0/0/0", mem_req, mem_addr, stall);
    end
    check_stats("abort");
    tick();
    fetch(32'h0000_0500, 0, -1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 250; n++) begin
      a = ((32'($urandom_range(0, 3)) * NL + 32'($urandom_range(0, NL-1))) * LINE_B)
          + 32'($urandom_range(0, 4*WPL-1));
      if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 7) == 0);
      fetch(a, $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? $urandom_range(0, WPL-1) : -1);
    end
    check_stats("random");
  endtask

  initial begin
    seq_mode = 1'b1;
    test_reset();
    test_basic_refill();
    test_conflict();
    test_slow_mem();
    test_inval_refill();
    test_inval_idle();
    test_reset_mid_refill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter NLINES, default 16, number of direct-mapped lines (power of two, >=2).
REQ-002 Parameter WPL, default 4, 32-bit words per line (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  fetch request from fetch stage this cycle.
REQ-006 pcF  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 inval  input  1  invalidate all lines.
REQ-008 instrF  output  32  instruction word for pcF, valid when en & ~stall.
REQ-009 stall  output  1  fetch must hold pcF and instrD.
REQ-010 mem_req  output  1  refill read request to backing memory.
REQ-011 mem_addr  output  32  word-aligned refill address.
REQ-012 mem_ready  input  1  mem_rdata valid; completes current beat.
REQ-013 mem_rdata  input  32  refill data word.
REQ-014 hit_count, miss_count  output  32 each  statistics counters.

Function
REQ-015 Address split: offset = pcF[log2(WPL)+1:2], index = next log2(NLINES) bits, tag = remaining upper bits.
REQ-016 States IDLE, REFILL; reset state IDLE.
REQ-017 IDLE, en, valid[index] & tag match: hit; instrF = data[index][offset] combinationally same cycle, stall=0.
REQ-018 IDLE, en, miss: stall=1 same cycle; latch line base address (pcF with offset and [1:0] zeroed); beat counter=0; next state REFILL.
REQ-019 IDLE, ~en: stall=0, no state change, instrF don't-care.
REQ-020 REFILL: stall=1; mem_req=1; mem_addr = latched base + 4*beat; pcF ignored.
REQ-021 REFILL, mem_ready: write mem_rdata to data[idx][beat]; beat increments; mem_req/mem_addr stay stable until mem_ready.
REQ-022 REFILL, mem_ready on beat WPL-1: write tag, set valid, next state IDLE; stall=1 that cycle; following cycle re-lookup hits.
REQ-023 Miss penalty with mem_ready tied high: WPL+1 stalled cycles.
REQ-024 mem_addr wraps modulo 2^32; beat counter wraps only via REQ-022.
REQ-025 inval in IDLE: all valid bits cleared at next edge; lookup in that same cycle uses pre-clear valid bits.
REQ-026 inval in REFILL: refill continues; all valid bits cleared at REFILL end, including the refilled line.
REQ-027 mem_req=0 and mem_addr=0 outside REFILL.

Reset
REQ-028 reset: state=IDLE, all valid=0, beat=0, stall=0, mem_req=0, mem_addr=0, counters=0; data/tag arrays not cleared.
REQ-029 reset mid-REFILL: refill aborted; no line marked valid; mem_req=0 next cycle.

Configuration
REQ-030 Macro ICACHE_STATS_EN defined: hit_count += 1 per IDLE hit cycle, miss_count += 1 per IDLE->REFILL transition, both saturating at 32'hFFFFFFFF.
REQ-031 ICACHE_STATS_EN undefined: counter logic absent; hit_count and miss_count tied to 0.

Structure
REQ-032 Package icache_pkg holds state enum type and width helpers (offset, index, tag bit widths).
REQ-033 Sub-module icache_data_array: NLINES x WPL word storage, one write port, one combinational read port.
REQ-034 Tag/valid storage and FSM live in icache.

Verification
REQ-035 Reset, en=1, pcF=0x0000_0040, mem_ready=1, mem_rdata=0x1000+4*beat -> stall 5 cycles, mem_addr 0x40,0x44,0x48,0x4C, then instrF=0x1000, stall=0.
REQ-036 After REQ-035, pcF=0x48 -> hit same cycle, instrF=0x1008, no mem_req; hit_count=1, miss_count=1 (stats on).
REQ-037 pcF=0x0000_0140 (same index, new tag) after REQ-035 -> miss, refill from 0x140, then pcF=0x40 misses again.
REQ-038 mem_ready low 3 cycles on each beat -> mem_addr stable while low, stall=1 for 4*WPL+1 cycles, correct words filled.
REQ-039 inval asserted mid-refill of 0x40 -> refill completes, next lookup of 0x40 misses.
REQ-040 reset asserted on beat 2 of refill -> mem_req=0 next cycle, subsequent fetch of same address misses.
